fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Control and output stage for the register-array FIFO storage block. It accepts words from an upstream valid/ready producer and computes `reg_push`, `next_wrptr`, `next_rdptr` and `next_numitem` for the storage block. It drains the storage into a registered output slot that faces a downstream valid/ready consumer. It also maintains the FIFO status: `almost_full`, a high-water mark, and a synchronous flush.

## Interface
- `ADDR_BW`, 1: storage address width; DEPTH = 2**ADDR_BW words.
- `DATA_BW`, 4: data word width.
- `AFULL_TH`, 2**ADDR_BW-1: `almost_full` threshold on the storage occupancy.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous clear, active-high.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block accepts the upstream word.
- `in_data`  in  DATA_BW  upstream word.
- `out_valid`  out  1  output slot holds a word.
- `out_ready`  in  1  downstream consumes the word.
- `out_data`  out  DATA_BW  output slot word.
- `reg_push`  out  1  write `reg_din` at the storage write pointer.
- `reg_din`  out  DATA_BW  equal to `in_data`.
- `next_wrptr`  out  ADDR_BW  next storage write pointer.
- `next_rdptr`  out  ADDR_BW  next storage read pointer.
- `next_numitem`  out  ADDR_BW+1  next storage occupancy.
- `wr_ptr`, `rd_ptr`  in  ADDR_BW  current storage pointers.
- `num_item`  in  ADDR_BW+1  current storage occupancy.
- `reg_dout`  in  DATA_BW  storage word at `rd_ptr`.
- `almost_full`  out  1  registered flag: occupancy >= AFULL_TH.
- `high_water`  out  ADDR_BW+1  maximum `next_numitem` since reset or flush.

## Operation
- Total capacity is DEPTH+1 words: the storage plus the output slot.
- `in_ready` = rst & ~flush & (num_item != DEPTH). The all-width compare is ADDR_BW+1 bits.
- push = in_valid & in_ready.
- load = ~out_valid | out_ready. The output slot may take a new word when load is 1.
- pop = load & (num_item != 0). On pop, `out_data` <= `reg_dout`.
- bypass = push & load & (num_item == 0). On bypass, `out_data` <= `in_data` and the storage is not written.
- push_arr = push & ~bypass. Then `reg_push` = push_arr.
- `next_wrptr` = wr_ptr + push_arr and `next_rdptr` = rd_ptr + pop. Both wrap modulo DEPTH through natural ADDR_BW truncation.
- `next_numitem` = num_item + push_arr − pop.
- `out_valid` next value:
  - 1 when pop or bypass occurs.
  - 0 when out_ready is 1 and neither pop nor bypass occurs.
  - Otherwise it holds.
- Simultaneous push and pop with a non-empty storage: both pointers advance and the occupancy is unchanged.
- When full (num_item == DEPTH), `in_ready` is 0 even if a pop occurs that cycle. There is no path from `out_ready` to `in_ready`.
- `almost_full` <= (`next_numitem` >= AFULL_TH).
- `high_water` <= max(`high_water`, `next_numitem`).
- Flush has the highest priority:
  - Combinationally in the flush cycle: `reg_push`=0, all `next_*`=0, `in_ready`=0.
  - On the clock edge: `out_valid`<=0, `almost_full`<=0, `high_water`<=0. `out_data` holds its value.
- Reset (`rst`=0), applied asynchronously at any time, including mid-transfer:
  - `out_valid`=0, `out_data`=all ones, `almost_full`=0, `high_water`=0.
  - Combinationally: `in_ready`=0, `reg_push`=0, all `next_*`=0.

## Timing
- All outputs are registered or are a function only of registered inputs (`num_item`, `wr_ptr`, `rd_ptr`) and of `flush`/`rst`. The exceptions are `reg_push` and `next_*`, which also depend on `in_valid` and `out_ready`.
- Latency from accept to `out_valid` is 1 cycle via bypass. Otherwise the word appears once all older words have drained.
- Throughput is 1 word per cycle sustained in both directions.
- Word order is strictly FIFO. No word is lost or duplicated, including across pointer wrap.
- `rst` deassertion: `in_ready` rises in the same cycle, so the first accept occurs on the first edge after release.

## Test plan
- Reset: assert `rst`=0 mid-stream with `out_valid`=1.
  - Immediately `out_valid`=0, `out_data`=0xF, `in_ready`=0 and `next_*`=0.
  - After release, `in_ready`=1.
- Bypass (ADDR_BW=1, DATA_BW=4), starting empty: push 0xA with `out_ready`=1.
  - In that cycle `reg_push`=0.
  - Next cycle `out_valid`=1 and `out_data`=0xA.
- Fill (`out_ready`=0, AFULL_TH=1): push 0x1, 0x2, 0x3.
  - 0x1 lands in the output slot; `num_item`=2, `in_ready`=0, `almost_full`=1.
  - A 4th push stalls.
  - Raising `out_ready` drains 0x1, 0x2, 0x3 on consecutive cycles.
  - `high_water`=2.
- Wrap: stream 0x0..0x9 with `in_valid`=1 and `out_ready` alternating 1/0.
  - Outputs appear in order 0x0..0x9.
  - `wr_ptr`/`rd_ptr` wrap 1→0 repeatedly with no loss or duplication.
- Concurrent push and pop at `num_item`=1 with `out_valid`=1 and `out_ready`=1:
  - `next_numitem`=1.
  - Both pointers increment.
  - `out_data` takes the older word.
- Flush at `num_item`=2, `out_valid`=1, with `in_valid`=1 in the same cycle:
  - The push is refused.
  - Next cycle `num_item`=0, pointers are 0, `out_valid`=0 and `high_water`=0.

Source files
------------

// File: rtl/fifo_ctrl.sv
// Control and output stage for a register-array FIFO: upstream accept, storage
// pointer/occupancy update, registered output slot with empty-path bypass, status.
module fifo_ctrl #(
  parameter int ADDR_BW  = 1,
  parameter int DATA_BW  = 4,
  parameter int AFULL_TH = 2**ADDR_BW-1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_BW-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_BW-1:0] out_data,
  output logic               reg_push,
  output logic [DATA_BW-1:0] reg_din,
  output logic [ADDR_BW-1:0] next_wrptr,
  output logic [ADDR_BW-1:0] next_rdptr,
  output logic [ADDR_BW:0]   next_numitem,
  input  logic [ADDR_BW-1:0] wr_ptr,
  input  logic [ADDR_BW-1:0] rd_ptr,
  input  logic [ADDR_BW:0]   num_item,
  input  logic [DATA_BW-1:0] reg_dout,
  output logic               almost_full,
  output logic [ADDR_BW:0]   high_water
);

  localparam logic [ADDR_BW:0] DEPTH_W = (ADDR_BW+1)'(2**ADDR_BW);
  localparam logic [ADDR_BW:0] AFULL_W = (ADDR_BW+1)'(AFULL_TH);

  logic               out_valid_q, out_valid_d;
  logic [DATA_BW-1:0] out_data_q, out_data_d;
  logic               almost_full_q, almost_full_d;
  logic [ADDR_BW:0]   high_water_q, high_water_d;

  logic active, stor_full, stor_empty;
  logic push, load, pop, bypass, push_arr;

  always_comb begin
    active     = rst & ~flush;
    stor_full  = (num_item == DEPTH_W);
    stor_empty = (num_item == '0);
    in_ready   = active & ~stor_full;
    push       = in_valid & in_ready;
    load       = ~out_valid_q | out_ready;
    pop        = active & load & ~stor_empty;
    // An empty storage with a free slot sends the word straight to the output.
    bypass     = push & load & stor_empty;
    push_arr   = push & ~bypass;
    reg_push   = push_arr;
    reg_din    = in_data;

    next_wrptr   = '0;
    next_rdptr   = '0;
    next_numitem = '0;
    if (active) begin
      next_wrptr   = wr_ptr + ADDR_BW'(push_arr);
      next_rdptr   = rd_ptr + ADDR_BW'(pop);
      next_numitem = num_item + (ADDR_BW+1)'(push_arr) - (ADDR_BW+1)'(pop);
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    almost_full_d = 1'b0;
    high_water_d  = '0;
    if (flush) begin
      out_valid_d = 1'b0;
    end else begin
      if (pop) begin
        out_valid_d = 1'b1;
        out_data_d  = reg_dout;
      end else if (bypass) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      almost_full_d = (next_numitem >= AFULL_W);
      high_water_d  = (next_numitem > high_water_q) ? next_numitem : high_water_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '1;
      almost_full_q <= 1'b0;
      high_water_q  <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      almost_full_q <= almost_full_d;
      high_water_q  <= high_water_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign almost_full = almost_full_q;
  assign high_water  = high_water_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: closes the loop with a register-array storage and checks
// every cycle against a whole-FIFO queue model (storage + output slot).
module tb_fifo_ctrl;
  localparam int AW = 1;
  localparam int DW = 4;
  localparam int DEPTH = 2;
  localparam int TH = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, reg_push, almost_full;
  logic [DW-1:0] in_data, out_data, reg_din, reg_dout;
  logic [AW-1:0] next_wrptr, next_rdptr, wr_ptr, rd_ptr;
  logic [AW:0]   next_numitem, num_item, high_water;

  fifo_ctrl #(.ADDR_BW(AW), .DATA_BW(DW), .AFULL_TH(TH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .reg_push(reg_push), .reg_din(reg_din),
    .next_wrptr(next_wrptr), .next_rdptr(next_rdptr), .next_numitem(next_numitem),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .num_item(num_item), .reg_dout(reg_dout),
    .almost_full(almost_full), .high_water(high_water)
  );

  // Storage block that the controller drives.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      num_item <= '0;
    end else begin
      wr_ptr   <= next_wrptr;
      rd_ptr   <= next_rdptr;
      num_item <= next_numitem;
      if (reg_push) mem[wr_ptr] <= reg_din;
    end
  end
  assign reg_dout = mem[rd_ptr];

  // Whole-FIFO model: q[0] is the word presented at the output.
  logic [DW-1:0] q[$];
  logic [DW-1:0] qa[$];
  logic [DW-1:0] last_m, last_a;
  int wr_m, rd_m, hw_m, wr_a, rd_a, hw_a;
  logic af_m, af_a;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_m = '1;
    wr_m = 0; rd_m = 0; hw_m = 0; af_m = 1'b0;
  endtask

  task automatic compare();
    int st, sa, pops;
    logic vexp, rdy, acc, cons, rp, run;
    logic [DW-1:0] dexp;
    run  = rst && !flush;
    st   = (q.size() > 0) ? q.size() - 1 : 0;
    vexp = (q.size() > 0);
    dexp = vexp ? q[0] : last_m;
    rdy  = run && (st != DEPTH);
    acc  = in_valid && rdy;
    cons = run && vexp && out_ready;
    qa = q;
    if (!run) qa.delete();
    else begin
      if (cons) void'(qa.pop_front());
      if (acc) qa.push_back(in_data);
    end
    sa   = (qa.size() > 0) ? qa.size() - 1 : 0;
    rp   = acc && (qa.size() > 1);
    pops = run ? (st + int'(rp) - sa) : 0;
    wr_a = run ? (wr_m + int'(rp)) % DEPTH : 0;
    rd_a = run ? (rd_m + pops) % DEPTH : 0;
    chk("out_valid", out_valid, vexp);
    chk("out_data", out_data, dexp);
    chk("in_ready", in_ready, rdy);
    chk("reg_push", reg_push, rp);
    chk("reg_din", reg_din, in_data);
    chk("next_wrptr", next_wrptr, wr_a);
    chk("next_rdptr", next_rdptr, rd_a);
    chk("next_numitem", next_numitem, sa);
    chk("almost_full", almost_full, af_m);
    chk("high_water", high_water, hw_m);
    chk("num_item", num_item, st);
    chk("wr_ptr", wr_ptr, wr_m);
    chk("rd_ptr", rd_ptr, rd_m);
    af_a   = run && (sa >= TH);
    hw_a   = run ? ((sa > hw_m) ? sa : hw_m) : 0;
    last_a = !rst ? '1 : ((qa.size() > 0) ? qa[0] : dexp);
  endtask

  // Called at posedge+1; compares at the falling edge, commits the model after the next rise.
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    q = qa; wr_m = wr_a; rd_m = rd_a; hw_m = hw_a; af_m = af_a; last_m = last_a;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [DW-1:0] rx[$];
  int nw, cyc;
  logic ord, accd;

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    step();
    chk("reset_out_data", out_data, 4'hF);
    chk("reset_out_valid", out_valid, 0);
    rst = 1'b1;
    #1 chk("release_in_ready", in_ready, 1);

    // Bypass into an empty FIFO.
    drive(1, 4'hA, 1, 0);
    #1 chk("bypass_reg_push", reg_push, 0);
    step();
    chk("bypass_out_valid", out_valid, 1);
    chk("bypass_out_data", out_data, 4'hA);
    drive(0, 0, 1, 0); step();

    // Fill with the consumer stalled.
    for (int i = 1; i <= 3; i++) begin
      drive(1, 4'(i), 0, 0); step();
    end
    drive(1, 4'h4, 0, 0);
    #1;
    chk("fill_num_item", num_item, 2);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_almost_full", almost_full, 1);
    chk("fill_out_data", out_data, 4'h1);
    step();
    chk("fill_stall_num", num_item, 2);
    chk("fill_high_water", high_water, 2);
    drive(0, 0, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, i);
      step();
    end
    chk("drained_valid", out_valid, 0);

    // Concurrent push and pop with one word in storage.
    drive(1, 4'hB, 0, 0); step();
    drive(1, 4'hC, 0, 0); step();
    drive(1, 4'hD, 1, 0);
    #1;
    chk("conc_next_numitem", next_numitem, 1);
    chk("conc_next_wrptr", next_wrptr, (wr_m + 1) % DEPTH);
    chk("conc_next_rdptr", next_rdptr, (rd_m + 1) % DEPTH);
    step();
    chk("conc_out_data", out_data, 4'hC);

    // Flush with two words in storage and a push offered.
    drive(1, 4'hE, 0, 0); step();
    drive(1, 4'hF, 0, 1);
    #1;
    chk("flush_num_before", num_item, 2);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_reg_push", reg_push, 0);
    chk("flush_next_numitem", next_numitem, 0);
    step();
    chk("flush_num_item", num_item, 0);
    chk("flush_wr_ptr", wr_ptr, 0);
    chk("flush_rd_ptr", rd_ptr, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_high_water", high_water, 0);

    // Stream 0..9 with alternating consumer readiness across pointer wrap.
    rx.delete(); nw = 0; cyc = 0; ord = 1'b1;
    while (rx.size() < 10 && cyc < 80) begin
      drive(nw < 10, nw[DW-1:0], ord, 0);
      #1;
      accd = in_valid && in_ready;
      if (out_valid && out_ready) rx.push_back(out_data);
      step();
      if (accd) nw++;
      ord = ~ord;
      cyc++;
    end
    chk("wrap_count", rx.size(), 10);
    for (int i = 0; i < rx.size(); i++) chk("wrap_order", rx[i], i);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom),
            (i < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0),
            $urandom_range(0, 39) == 0);
      step();
    end

    // Asynchronous reset mid-transfer.
    drive(0, 0, 1, 0); step();
    drive(1, 4'h7, 0, 0); step();
    drive(1, 4'h8, 0, 0); step();
    chk("pre_reset_valid", out_valid, 1);
    drive(1, 4'h9, 1, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_data", out_data, 4'hF);
    chk("async_in_ready", in_ready, 0);
    chk("async_reg_push", reg_push, 0);
    chk("async_next_wrptr", next_wrptr, 0);
    chk("async_next_rdptr", next_rdptr, 0);
    chk("async_next_numitem", next_numitem, 0);
    model_reset();
    step();
    rst = 1'b1;
    #1 chk("post_reset_in_ready", in_ready, 1);
    drive(1, 4'h5, 1, 0); step();
    chk("post_reset_data", out_data, 4'h5);
    drive(0, 0, 1, 0); step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
